patp_fetch_sequencer: RTL

Control sequencer for the PATP core's fetch/execute cycle. Fetches an instruction from program memory at the program counter and latches it. Drives the set/reset triggers of the fetch/execute phase flip-flop and hands each instruction to the datapath with a start/done handshake. Also owns the PC, halt handling, and watchdog error detection.

---
 rtl/patp_fetch_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/patp_fetch_sequencer.sv
// PATP fetch/execute control sequencer: fetches from program memory at pc,
// latches the instruction, drives the fetch/execute phase flip-flop triggers,
// hands instructions to the datapath, and owns pc, halt and watchdog errors.
module patp_fetch_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt_req,
    input  logic              fe_q,
    output logic              fe_set,
    output logic              fe_rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              exec_start,
    output logic [DATA_W-1:0] ir,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        EXEC_START = 3'd2,
        EXEC_WAIT  = 3'd3,
        ERROR      = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] ir_d;
    logic [1:0]        err_code_d;
    logic [WD_W-1:0]   wd, wd_d;
    logic              halt_flag, halt_flag_d;
    logic [2:0]        opcode;

    assign opcode   = ir[DATA_W-1 -: 3];
    assign mem_addr = pc;
    assign halted   = (state == IDLE);
    assign err      = (state == ERROR);

    // State, pc, ir, watchdog and error code registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            err_code  <= 2'b00;
            wd        <= '0;
            halt_flag <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            err_code  <= err_code_d;
            wd        <= wd_d;
            halt_flag <= halt_flag_d;
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        ir_d        = ir;
        err_code_d  = err_code;
        wd_d        = wd;
        halt_flag_d = halt_flag | (halt_req && (state != IDLE));
        fe_set      = 1'b0;
        fe_rst      = 1'b0;
        mem_req     = 1'b0;
        exec_start  = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    wd_d    = '0;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                // An ack landing on the final watchdog count is still accepted
                if ((wd == WD_MAX) && !mem_ack) begin
                    state_d    = ERROR;
                    err_code_d = 2'b01;
                end else if (fe_q) begin
                    state_d    = ERROR;
                    err_code_d = 2'b11;
                end else if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc + 1'b1;
                    fe_set  = 1'b1;
                    state_d = EXEC_START;
                    wd_d    = '0;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            EXEC_START: begin
                if (!fe_q) begin
                    state_d    = ERROR;
                    err_code_d = 2'b11;
                end else if (opcode == OP_HALT) begin
                    fe_rst  = 1'b1;
                    state_d = IDLE;
                end else begin
                    exec_start = 1'b1;
                    state_d    = EXEC_WAIT;
                    wd_d       = '0;
                end
            end
            EXEC_WAIT: begin
                if ((wd == WD_MAX) && !exec_done) begin
                    state_d    = ERROR;
                    err_code_d = 2'b10;
                end else if (!fe_q) begin
                    state_d    = ERROR;
                    err_code_d = 2'b11;
                end else if (exec_done) begin
                    fe_rst = 1'b1;
                    if (pc_load) begin
                        pc_d = pc_load_val;
                    end
                    if (halt_flag || halt_req) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                        wd_d    = '0;
                    end
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            ERROR: begin
                fe_rst = 1'b1;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        // Halt request is consumed whenever the sequencer parks in IDLE
        if (state_d == IDLE) begin
            halt_flag_d = 1'b0;
        end
    end

endmodule
